// File: rtl/axis_mac_accumulator_if.sv
// AXI-Stream bundle used on both sides of the MAC accumulator.
// tuser carries the beat count on the result stream and is unused on the
// product stream.
interface axis_mac_accumulator_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tuser, tlast, tvalid, input  tready);
  modport slave  (input  tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_mac_accumulator.sv
// Frame accumulator behind the AXIS multiplier: sums signed products until
// tlast, then emits one result beat carrying the sum and the beat count.
// Optional macro ACC_SAT_EN: clamp the result to the OUT_W signed range
// instead of passing the low OUT_W bits through.
module axis_mac_accumulator #(
  parameter int IN_W  = 64,
  parameter int ACC_W = 80,
  parameter int OUT_W = 64,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axis_mac_accumulator_if.slave          s_axis,
  axis_mac_accumulator_if.master         m_axis,
  output logic                           ovf
);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    fovf_q, fovf_d;   // ACC_W wrap seen in this frame
  logic [OUT_W-1:0]        dat_q, dat_d;
  logic [CNT_W-1:0]        usr_q, usr_d;
  logic                    ovf_q, ovf_d;

  logic                    m_valid, s_ready, in_fire;
  logic signed [ACC_W-1:0] in_ext, sum;
  logic                    wrap, fits;
  logic [CNT_W-1:0]        cnt_inc;
  logic [OUT_W-1:0]        out_val;

`ifdef ACC_SAT_EN
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
`endif

  assign m_valid = (state_q == HOLD);
  // An unaccepted result blocks new input so it cannot be overwritten.
  assign s_ready = rst_n && !(m_valid && !m_axis.tready);
  assign in_fire = s_axis.tvalid && s_ready;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tlast  = m_valid;
  assign m_axis.tdata  = dat_q;
  assign m_axis.tuser  = usr_q;
  assign ovf           = ovf_q;

  // Running sum, wrap detection, OUT_W range check and result formatting.
  always_comb begin
    in_ext  = ACC_W'($signed(s_axis.tdata));
    sum     = acc_q + in_ext;
    wrap    = (acc_q[ACC_W-1] == in_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    fits    = (sum == ACC_W'($signed(sum[OUT_W-1:0])));
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`ifdef ACC_SAT_EN
    out_val = fits ? sum[OUT_W-1:0] : (sum[ACC_W-1] ? OUT_MIN : OUT_MAX);
`else
    out_val = sum[OUT_W-1:0];
`endif
  end

  // Next state and datapath: accumulate, close the frame on tlast.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    fovf_d  = fovf_q;
    dat_d   = dat_q;
    usr_d   = usr_q;
    ovf_d   = ovf_q;

    case (state_q)
      ACCUM:   if (in_fire && s_axis.tlast) state_d = HOLD;
      HOLD:    if (m_axis.tready) state_d = (in_fire && s_axis.tlast) ? HOLD : ACCUM;
      default: state_d = ACCUM;
    endcase

    if (in_fire) begin
      if (s_axis.tlast) begin
        dat_d  = out_val;
        usr_d  = cnt_inc;
        ovf_d  = fovf_q | wrap | !fits;
        acc_d  = '0;
        cnt_d  = '0;
        fovf_d = 1'b0;
      end else begin
        acc_d  = sum;
        cnt_d  = cnt_inc;
        fovf_d = fovf_q | wrap;
      end
    end
  end

  // State and data registers; reset drops any partial frame and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      fovf_q  <= 1'b0;
      dat_q   <= '0;
      usr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      fovf_q  <= fovf_d;
      dat_q   <= dat_d;
      usr_q   <= usr_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_axis_mac_accumulator.sv
// Scoreboard bench for axis_mac_accumulator. A second instance with CNT_W=4
// sees the same stream to cover beat-count saturation.
module tb_axis_mac_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  logic ovf, ovf4;

  always #5 clk = ~clk;

  axis_mac_accumulator_if #(.DATA_W(64), .USER_W(1))  s_if ();
  axis_mac_accumulator_if #(.DATA_W(64), .USER_W(16)) m_if ();
  axis_mac_accumulator_if #(.DATA_W(64), .USER_W(1))  s4_if ();
  axis_mac_accumulator_if #(.DATA_W(64), .USER_W(4))  m4_if ();

  assign s4_if.tdata  = s_if.tdata;
  assign s4_if.tuser  = s_if.tuser;
  assign s4_if.tlast  = s_if.tlast;
  assign s4_if.tvalid = s_if.tvalid;
  assign m4_if.tready = m_if.tready;

  axis_mac_accumulator #(.IN_W(64), .ACC_W(80), .OUT_W(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if), .ovf(ovf));

  axis_mac_accumulator #(.IN_W(64), .ACC_W(80), .OUT_W(64), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .s_axis(s4_if), .m_axis(m4_if), .ovf(ovf4));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] d;
    int          cnt;
    logic        ovf;
  } exp_t;

  exp_t q[$];

  localparam logic signed [95:0] A_MAX = 96'sh0000_7FFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic signed [95:0] A_MIN = 96'shFFFF_8000_0000_0000_0000_0000;
  localparam logic signed [95:0] O_MAX = 96'sh0000_0000_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [95:0] O_MIN = 96'shFFFF_FFFF_8000_0000_0000_0000;

  logic signed [95:0] macc  = '0;
  int                 mcnt  = 0;
  logic               mfovf = 1'b0;

  function automatic void model_reset();
    macc  = '0;
    mcnt  = 0;
    mfovf = 1'b0;
  endfunction

  function automatic void model_accept(input logic [63:0] d, input logic l);
    logic signed [95:0] s, sx;
    logic               wrap, fits;
    exp_t               e;
    s    = macc + $signed({{32{d[63]}}, d});
    wrap = (s > A_MAX) || (s < A_MIN);
    sx   = $signed({{16{s[79]}}, s[79:0]});
    mcnt = mcnt + 1;
    if (!l) begin
      macc  = sx;
      mfovf = mfovf | wrap;
    end else begin
      fits = (sx <= O_MAX) && (sx >= O_MIN);
`ifdef ACC_SAT_EN
      e.d = fits ? sx[63:0] : (sx < 0 ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF);
`else
      e.d = sx[63:0];
`endif
      e.cnt = mcnt;
      e.ovf = mfovf | wrap | !fits;
      q.push_back(e);
      model_reset();
    end
  endfunction

  // Drive one beat and hold it until accepted; waited = stall cycles seen.
  task automatic send(input logic [63:0] d, input logic l, output int waited);
    bit ok;
    waited = 0;
    ok     = 1'b0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_if.tready) begin ok = 1'b1; break; end
      waited++;
      if (waited > 200) begin chk("s_ready_timeout", 0, 1); break; end
    end
    if (ok) begin
      @(posedge clk);
      model_accept(d, l);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  // Output monitor: pop and compare every accepted result beat.
  always @(negedge clk) begin
    if (rst_n && m_if.tvalid && m_if.tready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", m_if.tdata, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("tdata", m_if.tdata, e.d);
        chk("tuser", m_if.tuser, (e.cnt > 65535) ? 65535 : e.cnt);
        chk("tlast", m_if.tlast, 1);
        chk("ovf",   ovf, e.ovf);
        chk("c4_tdata", m4_if.tdata, e.d);
        chk("c4_tuser", m4_if.tuser, (e.cnt > 15) ? 15 : e.cnt);
      end
    end
  end

  initial begin
    int w;
    rst_n       = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;

    // reset state
    #12;
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tdata",  m_if.tdata, 0);
    chk("rst_tuser",  m_if.tuser, 0);
    chk("rst_tlast",  m_if.tlast, 0);
    chk("rst_ovf",    ovf, 0);
    chk("rst_sready", s_if.tready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic frame, 1-cycle latency
    send(64'd3, 1'b0, w);
    send(-64'sd5, 1'b0, w);
    send(64'd10, 1'b1, w);
    chk("latency_tvalid", m_if.tvalid, 1);
    chk("basic_q_head", q.size() > 0 ? q[0].d : 64'hDEAD, 64'd8);
    repeat (2) @(posedge clk); #1;

    // back-to-back single-beat frames at full rate
    send(64'd7, 1'b1, w);
    chk("b2b_wait0", w, 0);
    send(-64'sd7, 1'b1, w);
    chk("b2b_wait1", w, 0);
    chk("b2b_valid1", m_if.tvalid, 1);
    send(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, w);
    chk("b2b_wait2", w, 0);
    chk("b2b_valid2", m_if.tvalid, 1);
    repeat (2) @(posedge clk); #1;

    // output stall backpressures input
    m_if.tready = 1'b0;
    send(64'd1, 1'b0, w);
    send(64'd2, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_tvalid", m_if.tvalid, 1);
      chk("stall_tdata",  m_if.tdata, 3);
      chk("stall_sready", s_if.tready, 0);
    end
    @(posedge clk); #1;
    m_if.tready = 1'b1;
    send(64'd5, 1'b0, w);
    send(64'd6, 1'b1, w);
    repeat (2) @(posedge clk); #1;

    // OUT_W truncation / saturation
    send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, w);
    send(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, w);
    repeat (2) @(posedge clk); #1;
    // negative overflow
    send(64'h8000_0000_0000_0000, 1'b0, w);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
    repeat (2) @(posedge clk); #1;

    // reset mid-frame drops the partial sum
    send(64'd100, 1'b0, w);
    send(64'd200, 1'b0, w);
    rst_n = 1'b0;
    model_reset();
    #3;
    chk("midrst_tvalid", m_if.tvalid, 0);
    chk("midrst_sready", s_if.tready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(64'd4, 1'b0, w);
    send(64'd4, 1'b1, w);
    repeat (2) @(posedge clk); #1;

    // 20-beat frame: CNT_W=4 instance saturates at 15
    for (int i = 0; i < 20; i++) send(64'd1, (i == 19), w);
    repeat (4) @(posedge clk); #1;

    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_mac_accumulator.md
Name: axis_mac_accumulator

Overview:
- Downstream stage of the AXIS multiplier. Consumes the signed 64-bit product stream and sums every product in a frame; a frame is closed by tlast.
- Emits one AXIS result beat per frame, carrying the frame sum and the beat count.
- Closes dot-product / FIR-tap loops after the multiplier without software involvement.

Parameters:
- IN_W, 64, width of the signed input product.
- ACC_W, 80, width of the internal signed accumulator. Must be at least IN_W.
- OUT_W, 64, width of the signed result on the output. Must be at most ACC_W.
- CNT_W, 16, width of the per-frame beat counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- s_axis_tdata  input  IN_W  signed product from the multiplier
- s_axis_tlast  input  1  last product of the frame
- s_axis_tvalid  input  1  input beat valid
- s_axis_tready  output  1  input beat ready
- m_axis_tdata  output  OUT_W  signed frame sum
- m_axis_tuser  output  CNT_W  number of beats in the frame
- m_axis_tlast  output  1  constant 1 whenever m_axis_tvalid is 1 (one beat per frame)
- m_axis_tvalid  output  1  result valid
- m_axis_tready  input  1  result ready
- ovf  output  1  sticky flag: ACC_W wrap or OUT_W truncation/saturation in the current output frame

Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values:
  - acc = 0, cnt = 0, state = ACCUM.
  - m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tlast = 0, m_axis_tvalid = 0, ovf = 0.
  - s_axis_tready = 0 while rst_n is low.
- Reset asserted mid-frame discards the partial sum and any pending result. No output beat is produced for that frame.
- Handshakes:
  - s_axis_tready = rst_n && !(m_axis_tvalid && !m_axis_tready). A pending, unaccepted result stalls the input.
  - Input beat accepted when s_axis_tvalid && s_axis_tready. Output beat accepted when m_axis_tvalid && m_axis_tready.
- States:
  - ACCUM: accumulating. An accepted beat with tlast=0 does acc += sign_extend(tdata) and cnt += 1 (cnt saturates at all-ones), then stays in ACCUM.
  - ACCUM, accepted beat with tlast=1:
    - Loads the output registers with the total sum = acc + sign_extend(tdata) and count = cnt + 1 (saturating).
    - Clears acc and cnt to 0.
    - Goes to HOLD with m_axis_tvalid=1 on the next cycle. Latency is 1 clock from the last input beat to the result.
  - HOLD: m_axis_tvalid=1; tdata, tuser and ovf stay stable until accepted.
    - If m_axis_tready=1 in a cycle, the result is consumed.
    - In that same cycle an input beat may also be accepted (ready is high), and it is processed as in ACCUM.
    - A tlast beat in that cycle reloads the output registers, so m_axis_tvalid stays 1 back-to-back (single-beat frames run at full rate).
    - Otherwise the block returns to ACCUM with m_axis_tvalid=0.
- Arithmetic:
  - All arithmetic is two's complement.
  - ACC_W overflow wraps and sets an internal frame-overflow bit.
  - Output = low OUT_W bits of the ACC_W sum, unless ACC_SAT_EN is defined.
  - Truncation that changes the value sets ovf for that result.
  - The frame-overflow bit clears together with acc.
- Frames of any length ≥ 1 beat are legal. A single-beat frame outputs the input value with tuser=1.

Optional Feature:
- Macro ACC_SAT_EN.
- Defined: when the ACC_W sum exceeds the OUT_W signed range, m_axis_tdata clamps to +2^(OUT_W-1)-1 or -2^(OUT_W-1), and ovf=1.
- Not defined: the low OUT_W bits are passed through (wrap), and ovf still flags the truncation.
- ACC_W wrap-around is never saturated.

Test Plan:
- Reset, then frame 3, -5, 10 (tlast on 10), m_axis_tready=1 → one result beat one cycle after the tlast beat: tdata=8, tuser=3, tlast=1, ovf=0.
- Back-to-back single-beat frames 7, -7, 0x7FFFFFFF_FFFFFFFF with tready held high → consecutive results 7, -7, 0x7FFF..FF, each tuser=1, tvalid continuously 1, s_axis_tready never drops.
- Frame 1, 2 completed while m_axis_tready=0 for 5 cycles → s_axis_tready=0 during the stall, result 3 held stable. Next frame starts only after acceptance and sums correctly.
- Two beats of 0x7FFFFFFF_FFFFFFFF with OUT_W=64 → without ACC_SAT_EN: tdata=0xFFFFFFFF_FFFFFFFE, ovf=1. With ACC_SAT_EN: tdata=0x7FFFFFFF_FFFFFFFF, ovf=1.
- rst_n pulsed low after two beats of an in-progress frame, then frame 4, 4 (tlast) → no result from the aborted frame; the next result is tdata=8, tuser=2.
- Counter saturation with CNT_W=4: frame of 20 beats of value 1 → tdata=20, tuser=15.
